// File: rtl/tia_horizontal_decode_pkg.sv
// Horizontal timing constants shared by the TIA horizontal decoder and the
// object position counters.
//   - PAT_*    : 6-bit horizontal LFSR patterns for each decoded line count
//   - LN_*     : the line count (ticks after the shb tick) of each pattern
//   - LINE_LEN : ticks per line (line counts 0..56)
//   - dec_idx_e / dec_t : decode index and decode result
package tia_horizontal_decode_pkg;

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned LINE_LEN = 57;
  localparam int unsigned NUM_DEC  = 7;

  // LFSR patterns (count 0 is 000000, LFSR shifts right with XNOR feedback).
  localparam logic [CNT_W-1:0] PAT_SHS  = 6'b111100;
  localparam logic [CNT_W-1:0] PAT_RHS  = 6'b110111;
  localparam logic [CNT_W-1:0] PAT_RCB  = 6'b001111;
  localparam logic [CNT_W-1:0] PAT_RHB  = 6'b011100;
  localparam logic [CNT_W-1:0] PAT_LRHB = 6'b010111;
  localparam logic [CNT_W-1:0] PAT_CNT  = 6'b101100;
  localparam logic [CNT_W-1:0] PAT_END  = 6'b010100;
  // All-ones is the XNOR-LFSR lock-up state; a healthy counter never reaches it.
  localparam logic [CNT_W-1:0] PAT_LOCK = 6'b111111;

  localparam logic [CNT_W-1:0] LN_SHS  = 6'd4;
  localparam logic [CNT_W-1:0] LN_RHS  = 6'd8;
  localparam logic [CNT_W-1:0] LN_RCB  = 6'd12;
  localparam logic [CNT_W-1:0] LN_RHB  = 6'd16;
  localparam logic [CNT_W-1:0] LN_LRHB = 6'd18;
  localparam logic [CNT_W-1:0] LN_CNT  = 6'd36;
  localparam logic [CNT_W-1:0] LN_END  = 6'd56;

  typedef enum logic [2:0] {
    DEC_SHS  = 3'd0,
    DEC_RHS  = 3'd1,
    DEC_RCB  = 3'd2,
    DEC_RHB  = 3'd3,
    DEC_LRHB = 3'd4,
    DEC_CNT  = 3'd5,
    DEC_END  = 3'd6
  } dec_idx_e;

  typedef struct packed {
    logic     hit;
    dec_idx_e idx;
  } dec_t;

  // Equality decode of an LFSR pattern; patterns are distinct so at most one hits.
  function automatic dec_t decode(input logic [CNT_W-1:0] cnt);
    dec_t d;
    d.hit = 1'b1;
    d.idx = DEC_SHS;
    case (cnt)
      PAT_SHS:  d.idx = DEC_SHS;
      PAT_RHS:  d.idx = DEC_RHS;
      PAT_RCB:  d.idx = DEC_RCB;
      PAT_RHB:  d.idx = DEC_RHB;
      PAT_LRHB: d.idx = DEC_LRHB;
      PAT_CNT:  d.idx = DEC_CNT;
      PAT_END:  d.idx = DEC_END;
      default:  d.hit = 1'b0;
    endcase
    return d;
  endfunction

  // Line count at which a decode is legal.
  function automatic logic [CNT_W-1:0] dec_line(input dec_idx_e idx);
    logic [CNT_W-1:0] ln;
    case (idx)
      DEC_SHS:  ln = LN_SHS;
      DEC_RHS:  ln = LN_RHS;
      DEC_RCB:  ln = LN_RCB;
      DEC_RHB:  ln = LN_RHB;
      DEC_LRHB: ln = LN_LRHB;
      DEC_CNT:  ln = LN_CNT;
      default:  ln = LN_END;
    endcase
    return ln;
  endfunction

endpackage

// File: rtl/tia_sr_latch.sv
// Clocked set/clear level with clock enable and selectable set/clear priority.
//   clk, rst : clock, asynchronous active-high reset (q_o <= RST_VAL)
//   en_i     : update enable; q_o holds while low
//   set_i    : drive q_o high
//   clr_i    : drive q_o low
//   q_o      : registered level
module tia_sr_latch #(
  parameter bit SET_WINS = 1'b1,
  parameter bit RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);

  logic q_d;

  // Next level: set/clear only when enabled; SET_WINS breaks the tie.
  always_comb begin
    q_d = q_o;
    if (en_i) begin
      if (set_i && (SET_WINS || !clr_i)) begin
        q_d = 1'b1;
      end else if (clr_i) begin
        q_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= RST_VAL;
    end else begin
      q_o <= q_d;
    end
  end

endmodule

// File: rtl/tia_horizontal_decode.sv
// TIA horizontal timing decoder: turns the horizontal LFSR count into the
// line-rate sync, blank and burst levels, and watches line framing.
//   clk, reset  : system clock, asynchronous active-high reset
//   tick        : one-clk enable per horizontal LFSR step
//   count       : LFSR pattern, valid when tick=1
//   shb         : line-start strobe, valid when tick=1
//   hmove       : HMOVE strobe, accepted on any cycle
//   hsync       : horizontal sync level
//   hblank      : horizontal blank level
//   cburst      : colour-burst gate level
//   center      : one-tick pulse at the line centre
//   late_hblank : HMOVE-extended blank latch
//   sync_err    : sticky loss-of-framing flag
module tia_horizontal_decode
  import tia_horizontal_decode_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [CNT_W-1:0] count,
  input  logic             shb,
  input  logic             hmove,
  output logic             hsync,
  output logic             hblank,
  output logic             cburst,
  output logic             center,
  output logic             late_hblank,
  output logic             sync_err
);

  localparam logic [CNT_W-1:0] SHADOW_MAX = '1;

  dec_t             dec_c;
  logic             dec_en_c;
  logic             shs_c, rhs_c, rcb_c, rhb_c, lrhb_c, cnt_c, end_c;
  logic             hb_clr_c;
  logic [CNT_W-1:0] line_n_c;
  logic             overrun_c, lock_c, misplaced_c;

  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             armed_q, armed_d;
  logic             sync_err_q, sync_err_d;
  logic             center_q, center_d;

  // Pattern decode; an shb tick masks every other decode.
  assign dec_c    = decode(count);
  assign dec_en_c = tick & ~shb & dec_c.hit;
  assign shs_c    = dec_en_c & (dec_c.idx == DEC_SHS);
  assign rhs_c    = dec_en_c & (dec_c.idx == DEC_RHS);
  assign rcb_c    = dec_en_c & (dec_c.idx == DEC_RCB);
  assign rhb_c    = dec_en_c & (dec_c.idx == DEC_RHB);
  assign lrhb_c   = dec_en_c & (dec_c.idx == DEC_LRHB);
  assign cnt_c    = dec_en_c & (dec_c.idx == DEC_CNT);
  assign end_c    = dec_en_c & (dec_c.idx == DEC_END);

  // Normal blank ends at RHB; after an HMOVE it is held until LRHB.
  assign hb_clr_c = (rhb_c & ~late_hblank) | lrhb_c;

  // Line count this tick carries, from the saturating shadow counter.
  assign line_n_c    = (shadow_q == SHADOW_MAX) ? shadow_q : shadow_q + CNT_W'(1);
  assign overrun_c   = (line_n_c >= CNT_W'(LINE_LEN));
  assign lock_c      = (count == PAT_LOCK);
  assign misplaced_c = dec_c.hit & (line_n_c != dec_line(dec_c.idx));

  // Shadow counter, framing arm, sticky error and centre pulse.
  always_comb begin
    shadow_d   = shadow_q;
    armed_d    = armed_q;
    sync_err_d = sync_err_q;
    center_d   = center_q;
    if (tick) begin
      center_d = cnt_c;
      if (shb) begin
        shadow_d = '0;
        armed_d  = 1'b1;
      end else begin
        shadow_d = line_n_c;
        // Checks stay off until the first shb after reset establishes framing.
        if (armed_q && (overrun_c || lock_c || misplaced_c)) begin
          sync_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q   <= '0;
      armed_q    <= 1'b0;
      sync_err_q <= 1'b0;
      center_q   <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      armed_q    <= armed_d;
      sync_err_q <= sync_err_d;
      center_q   <= center_d;
    end
  end

  assign center   = center_q;
  assign sync_err = sync_err_q;

  // Sync level: SHS..RHS.
  tia_sr_latch #(.SET_WINS(1'b0), .RST_VAL(1'b0)) u_hsync (
    .clk   (clk),
    .rst   (reset),
    .en_i  (tick),
    .set_i (shs_c),
    .clr_i (rhs_c),
    .q_o   (hsync)
  );

  // Burst gate: RHS..RCB, so it never overlaps hsync.
  tia_sr_latch #(.SET_WINS(1'b0), .RST_VAL(1'b0)) u_cburst (
    .clk   (clk),
    .rst   (reset),
    .en_i  (tick),
    .set_i (rhs_c),
    .clr_i (rcb_c),
    .q_o   (cburst)
  );

  // Blank: set at line start, cleared at RHB or LRHB.
  tia_sr_latch #(.SET_WINS(1'b1), .RST_VAL(1'b1)) u_hblank (
    .clk   (clk),
    .rst   (reset),
    .en_i  (tick),
    .set_i (shb),
    .clr_i (hb_clr_c),
    .q_o   (hblank)
  );

  // HMOVE latch: hmove is taken on any clk and beats a coincident END.
  tia_sr_latch #(.SET_WINS(1'b1), .RST_VAL(1'b0)) u_late_hblank (
    .clk   (clk),
    .rst   (reset),
    .en_i  (1'b1),
    .set_i (hmove),
    .clr_i (end_c),
    .q_o   (late_hblank)
  );

endmodule

// File: tb/tb_tia_horizontal_decode.sv
module tb_tia_horizontal_decode;

  typedef struct packed {
    logic hsync;
    logic hblank;
    logic cburst;
    logic center;
    logic late;
    logic err;
  } obs_t;

  localparam obs_t RESET_OBS = 6'b010000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [5:0] count = 6'd0;
  logic       shb = 1'b0;
  logic       hmove = 1'b0;
  logic       hsync, hblank, cburst, center, late_hblank, sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  obs_t sb_q[$];
  int   sb_n[$];

  // Reference model state: values expected after the current tick edge.
  logic m_hsync = 1'b0, m_hblank = 1'b1, m_cburst = 1'b0;
  logic m_center = 1'b0, m_late = 1'b0, m_err = 1'b0;
  bit   framed = 1'b0, armed = 1'b0;
  int   n = 0;

  tia_horizontal_decode dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .count       (count),
    .shb         (shb),
    .hmove       (hmove),
    .hsync       (hsync),
    .hblank      (hblank),
    .cburst      (cburst),
    .center      (center),
    .late_hblank (late_hblank),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // Horizontal LFSR model: 000000 at line count 0, shift right, XNOR feedback.
  function automatic logic [5:0] lfsr_at(input int steps);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < steps; i++) c = {~(c[1] ^ c[0]), c[5:1]};
    return c;
  endfunction

  // Line count a pattern belongs to, or -1 if it is not a decoded pattern.
  function automatic int pat_line(input logic [5:0] c);
    int lines [7];
    lines = '{4, 8, 12, 16, 18, 36, 56};
    for (int i = 0; i < 7; i++) if (c == lfsr_at(lines[i])) return lines[i];
    return -1;
  endfunction

  function automatic obs_t observed();
    return {hsync, hblank, cburst, center, late_hblank, sync_err};
  endfunction

  task automatic model_reset();
    m_hsync = 1'b0; m_hblank = 1'b1; m_cburst = 1'b0;
    m_center = 1'b0; m_late = 1'b0; m_err = 1'b0;
    framed = 1'b0; armed = 1'b0; n = 0;
  endtask

  // One idle clk (optional hmove) then one tick clk; expected result is queued.
  task automatic drive_tick(input logic [5:0] c, input bit s, input bit hm, input bit idle_hm);
    bit   was_armed;
    int   d;
    obs_t e;
    @(negedge clk);
    hmove = idle_hm;
    @(negedge clk);
    hmove = hm; tick = 1'b1; count = c; shb = s;
    if (idle_hm) m_late = 1'b1;
    was_armed = armed;
    if (s) begin
      n = 0; framed = 1'b1;
    end else if (framed && n < 63) begin
      n++;
    end
    d = pat_line(c);
    if (was_armed && !s && (n >= 57 || c == 6'h3F || (d >= 0 && d != n))) m_err = 1'b1;
    m_center = framed && !s && (n == 36);
    if (s) begin
      m_hblank = 1'b1;
    end else if (framed) begin
      case (n)
        4:  m_hsync = 1'b1;
        8:  begin m_hsync = 1'b0; m_cburst = 1'b1; end
        12: m_cburst = 1'b0;
        16: if (!m_late) m_hblank = 1'b0;
        18: m_hblank = 1'b0;
        56: if (!hm) m_late = 1'b0;
        default: ;
      endcase
    end
    if (hm) m_late = 1'b1;
    if (s) armed = 1'b1;
    e = {m_hsync, m_hblank, m_cburst, m_center, m_late, m_err};
    sb_q.push_back(e);
    sb_n.push_back(n);
    @(posedge clk);
    #1;
    tick = 1'b0; shb = 1'b0; hmove = 1'b0;
  endtask

  task automatic run_line(input int first, input int last, input int hm_a, input int hm_b,
                          input int idle_hm_at);
    for (int k = first; k <= last; k++)
      drive_tick(lfsr_at(k), k == 0, (k == hm_a) || (k == hm_b), k == idle_hm_at);
  endtask

  // Scoreboard: compare the queued expectation after every tick edge.
  always @(posedge clk) begin
    obs_t got, exp;
    int   tn;
    if (tick && !reset) begin
      #1;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: tick edge with no expected entry");
      end else begin
        exp = sb_q.pop_front();
        tn  = sb_n.pop_front();
        got = observed();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL tick_outputs n=%0d {hsync,hblank,cburst,center,late,err} got %b expected %b",
                   tn, got, exp);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (observed() !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_values got %b expected %b", observed(), RESET_OBS);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_unframed();
    drive_tick(6'h3F, 1'b0, 1'b0, 1'b0);
    drive_tick(lfsr_at(56), 1'b0, 1'b0, 1'b0);
    drive_tick(6'h2A, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL unframed_err_suppressed got %b expected 0", sync_err);
    end
  endtask

  task automatic test_normal_line();
    run_line(0, 56, -1, -1, -1);
    n_checks++;
    if ({hblank, late_hblank, sync_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL normal_line_end {hblank,late,err} got %b expected 000",
               {hblank, late_hblank, sync_err});
    end
  endtask

  task automatic test_hmove();
    run_line(0, 56, 40, 56, -1);
    n_checks++;
    if (late_hblank !== 1'b1) begin
      n_fail++;
      $display("FAIL hmove_end_coincide late got %b expected 1", late_hblank);
    end
    run_line(0, 17, -1, -1, -1);
    n_checks++;
    if (hblank !== 1'b1) begin
      n_fail++;
      $display("FAIL late_blank_held_n18 hblank got %b expected 1", hblank);
    end
    run_line(18, 56, -1, -1, -1);
    n_checks++;
    if ({hblank, late_hblank} !== 2'b00) begin
      n_fail++;
      $display("FAIL late_blank_released {hblank,late} got %b expected 00", {hblank, late_hblank});
    end
    run_line(0, 56, -1, -1, 10);
    n_checks++;
    if (late_hblank !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hmove_line_end late got %b expected 0", late_hblank);
    end
  endtask

  task automatic test_decode_mismatch();
    run_line(0, 19, -1, -1, -1);
    drive_tick(lfsr_at(56), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (sync_err !== 1'b1) begin
      n_fail++;
      $display("FAIL misplaced_end got %b expected 1", sync_err);
    end
  endtask

  task automatic test_reset_midline();
    run_line(0, 6, -1, -1, -1);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (observed() !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_midline_async got %b expected %b", observed(), RESET_OBS);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_line(0, 56, -1, -1, -1);
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midline_relock err got %b expected 0", sync_err);
    end
  endtask

  task automatic test_lock();
    run_line(0, 10, -1, -1, -1);
    drive_tick(6'h3F, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (sync_err !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_state got %b expected 1", sync_err);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (observed() !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_after_lock got %b expected %b", observed(), RESET_OBS);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_missing_shb();
    run_line(0, 56, -1, -1, -1);
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL missing_shb_before got %b expected 0", sync_err);
    end
    drive_tick(lfsr_at(57), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (sync_err !== 1'b1) begin
      n_fail++;
      $display("FAIL missing_shb_tick57 got %b expected 1", sync_err);
    end
    for (int k = 58; k <= 60; k++) drive_tick(lfsr_at(k), 1'b0, 1'b0, 1'b0);
    run_line(0, 56, -1, -1, -1);
    n_checks++;
    if (sync_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_err_sticky got %b expected 1", sync_err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unframed();
    test_normal_line();
    test_hmove();
    test_decode_mismatch();
    test_reset_midline();
    test_lock();
    test_missing_shb();
    #20;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tia_horizontal_decode.md
TIA_HORIZONTAL_DECODE -- requirements
Module: tia_horizontal_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port tick, input, 1 bit: clock enable, high for one clk cycle on each horizontal LFSR step (once per 4 color clocks).
REQ-004 SHALL have port count, input, 6 bits: the horizontal LFSR pattern, sampled only when tick=1.
REQ-005 SHALL have port shb, input, 1 bit: LFSR wrap/reset strobe (line start), sampled only when tick=1.
REQ-006 SHALL have port hmove, input, 1 bit: HMOVE strobe, one clk cycle wide, accepted on any cycle.
REQ-007 SHALL have port hsync, output, 1 bit: horizontal sync level.
REQ-008 SHALL have port hblank, output, 1 bit: horizontal blank level.
REQ-009 SHALL have port cburst, output, 1 bit: color-burst gate level.
REQ-010 SHALL have port center, output, 1 bit: one-tick pulse at the line centre.
REQ-011 SHALL have port late_hblank, output, 1 bit: HMOVE-extended blank latch.
REQ-012 SHALL have port sync_err, output, 1 bit: sticky flag for loss of line framing.

Function
REQ-013 SHALL treat "line count N" as N ticks after the tick carrying shb=1; N=0 is the shb tick itself.
REQ-014 SHALL decode the count patterns for line counts 4 (SHS), 8 (RHS), 12 (RCB), 16 (RHB), 18 (LRHB), 36 (CNT) and 56 (END) by equality against package constants.
REQ-015 SHALL update every output at the rising edge of a tick=1 cycle, giving one clk of latency from decode to output; with tick=0 outputs hold, except as stated in REQ-021.
REQ-016 SHALL set hblank on shb; on RHB it SHALL clear hblank if late_hblank=0; on LRHB it SHALL clear hblank unconditionally.
REQ-017 SHALL set hsync on SHS and clear hsync on RHS, so hsync is high for exactly 4 ticks.
REQ-018 SHALL set cburst on RHS and clear cburst on RCB; cburst and hsync are never high together.
REQ-019 SHALL drive center high for exactly the tick interval that follows the CNT decode, then low.
REQ-020 SHALL set late_hblank on an hmove cycle, and clear it on the END decode.
REQ-021 When hmove and an END decode coincide, set SHALL win.
REQ-022 When shb and any other decode coincide, shb actions SHALL take effect and the other decodes SHALL be ignored.
REQ-023 SHALL keep an internal 6-bit binary shadow counter: cleared to 0 on shb, otherwise incremented on each tick, saturating at 63.
REQ-024 SHALL set sync_err when the shadow counter reaches 57 without shb.
REQ-025 SHALL set sync_err when any decoded pattern from REQ-014 arrives at a shadow count other than its own N.
REQ-026 SHALL set sync_err when count=111111, the LFSR lock state.
REQ-027 Once set, sync_err SHALL clear only on reset.

Reset
REQ-028 While reset is high, SHALL force hsync=0, hblank=1, cburst=0, center=0, late_hblank=0, sync_err=0 and shadow counter=0, independent of clk.
REQ-029 After reset deasserts, SHALL suppress sync_err checks until the first shb tick; a reset mid-line restarts framing cleanly.

Structure
REQ-030 SHALL place the seven count-pattern constants, the line length (57) and the decode index enumeration in a shared tia horizontal timing package, for reuse by the object position counters.
REQ-031 SHALL implement set/clear levels with one natural sub-module, tia_sr_latch (set, clear, priority parameter, clock enable), instantiated for hsync, hblank, cburst and late_hblank.

Verification
REQ-032 SHALL cover a normal line: drive an LFSR model with shb at N=0 -> hsync high for N=5..8, cburst high for N=9..12, hblank low from N=17, center high at N=37 only, sync_err=0.
REQ-033 SHALL cover HMOVE: hmove pulse at N=40 of the prior line -> next line hblank clears at N=19, not N=17; late_hblank clears after N=56.
REQ-034 SHALL cover simultaneity: hmove in the same clk as the END tick -> late_hblank stays 1.
REQ-035 SHALL cover missing shb: suppress shb after N=56 -> sync_err=1 after the 57th tick and remains 1 after later valid lines.
REQ-036 SHALL cover the lock state: count=111111 with tick=1 -> sync_err=1 one clk later.
REQ-037 SHALL cover reset mid-line: assert reset at N=6 -> outputs take REQ-028 values immediately; after deassert and a new shb, timing matches REQ-032.
